// File: rtl/scrambler_pkg.sv
// Shared PCIe Gen1/Gen2 scrambler constants and the 8-step LFSR helper.
package scrambler_pkg;

  localparam int unsigned SYM_W  = 8;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned GAP_W  = 16;

  localparam logic [SYM_W-1:0]  K28_5_COM = 8'hBC;
  localparam logic [SYM_W-1:0]  K28_0_SKP = 8'h1C;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hFFFF;
  // x^5 + x^4 + x^3 + 1 feedback taps of G(x) = x^16+x^5+x^4+x^3+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h0039;

  typedef struct packed {
    logic [LFSR_W-1:0] next_lfsr;
    logic [SYM_W-1:0]  scramble_byte;
  } lfsr_step_t;

  // Eight Galois steps; scramble bit i is lfsr[15] before step i (LSB first).
  function automatic lfsr_step_t lfsr_adv8(input logic [LFSR_W-1:0] lfsr);
    lfsr_step_t        res;
    logic [LFSR_W-1:0] s;
    s   = lfsr;
    res = '0;
    for (int i = 0; i < int'(SYM_W); i++) begin
      res.scramble_byte[i] = s[LFSR_W-1];
      s = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_TAPS : LFSR_W'(0));
    end
    res.next_lfsr = s;
    return res;
  endfunction

endpackage

// File: rtl/pcie_lfsr8.sv
// 16-bit scrambler LFSR with seed load, hold and 8-step advance.
module pcie_lfsr8
  import scrambler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_seed_i,
  input  logic             advance_i,
  output logic [SYM_W-1:0] scramble_byte_c
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;
  lfsr_step_t        step_c;

  assign step_c          = lfsr_adv8(lfsr_q);
  assign scramble_byte_c = step_c.scramble_byte;

  // Seed load has priority over advance; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_seed_i) begin
      lfsr_d = LFSR_SEED;
    end else if (advance_i) begin
      lfsr_d = step_c.next_lfsr;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/scrambler_pcie_rx.sv
// Receive-side PCIe descrambler that syncs on COM, holds on SKP and tracks lock.
module scrambler_pcie_rx
  import scrambler_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [SYM_W-1:0] din,
  input  logic             k_in,
  input  logic             dis_scrambler_in,
  output logic             valid_out,
  output logic [SYM_W-1:0] dout,
  output logic             k_out,
  output logic             dis_scrambler_out,
  output logic             locked,
  output logic             lock_lost
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;
  // Gap value that, once one more non-COM arrives, hits the timeout.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOCK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(LOCK_TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             valid_q, valid_d;
  logic [SYM_W-1:0] dout_q, dout_d;
  logic             k_q, k_d;
  logic             dis_q, dis_d;
  logic             lost_q, lost_d;

  logic             is_com_c;
  logic             is_skp_c;
  logic             load_seed_c;
  logic             advance_c;
  logic [SYM_W-1:0] scramble_c;

  assign is_com_c    = k_in && (din == K28_5_COM);
  assign is_skp_c    = k_in && (din == K28_0_SKP);
  assign load_seed_c = valid_in && is_com_c;
  assign advance_c   = valid_in && !is_com_c && !is_skp_c;

  pcie_lfsr8 u_lfsr (
    .clk             (clk),
    .rst             (rst),
    .load_seed_i     (load_seed_c),
    .advance_i       (advance_c),
    .scramble_byte_c (scramble_c)
  );

  // Next-state: lock FSM, gap counter and output payload for an accepted symbol.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    valid_d = valid_in;
    dout_d  = dout_q;
    k_d     = k_q;
    dis_d   = dis_q;
    lost_d  = 1'b0;
    if (valid_in) begin
      k_d    = k_in;
      dis_d  = dis_scrambler_in;
      dout_d = din;
      if (!k_in && (state_q == ST_LOCKED) && !dis_scrambler_in) begin
        dout_d = din ^ scramble_c;
      end
      if (is_com_c) begin
        state_d = ST_LOCKED;
        gap_d   = '0;
      end else if (state_q == ST_LOCKED) begin
        if (gap_q >= GAP_LAST) begin
          state_d = ST_UNLOCKED;
          gap_d   = GAP_MAX;
          lost_d  = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
      gap_q   <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      k_q     <= 1'b0;
      dis_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      k_q     <= k_d;
      dis_q   <= dis_d;
      lost_q  <= lost_d;
    end
  end

  assign valid_out         = valid_q;
  assign dout              = dout_q;
  assign k_out             = k_q;
  assign dis_scrambler_out = dis_q;
  assign locked            = (state_q == ST_LOCKED);
  assign lock_lost         = lost_q;

endmodule

// File: tb/tb_scrambler_pcie_rx.sv
// Bench for scrambler_pcie_rx: directed steps plus randomized end-to-end stream.
module tb_scrambler_pcie_rx;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [7:0] din;
  logic       k_in;
  logic       dis_scrambler_in;

  logic       valid_a, k_a, dis_a, locked_a, lost_a;
  logic [7:0] dout_a;
  logic       valid_t, k_t, dis_t, locked_t, lost_t;
  logic [7:0] dout_t;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = default-timeout instance, 1 = timeout-16 instance.
  int         tmo[2] = '{2048, 16};
  int         m_idx[2];
  bit         m_locked[2];
  int         m_gap[2];
  logic [7:0] e_dout[2];
  logic       e_lost[2];
  logic       e_valid, e_k, e_dis;
  logic [7:0] ks[2048];

  scrambler_pcie_rx u_dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .k_in(k_in),
    .dis_scrambler_in(dis_scrambler_in), .valid_out(valid_a), .dout(dout_a),
    .k_out(k_a), .dis_scrambler_out(dis_a), .locked(locked_a), .lock_lost(lost_a)
  );

  scrambler_pcie_rx #(.LOCK_TIMEOUT(16)) u_dut_t (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din(din), .k_in(k_in),
    .dis_scrambler_in(dis_scrambler_in), .valid_out(valid_t), .dout(dout_t),
    .k_out(k_t), .dis_scrambler_out(dis_t), .locked(locked_t), .lock_lost(lost_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Keystream byte n = scramble byte applied to the n-th advancing symbol after a seed.
  task automatic build_keystream();
    logic [15:0] s;
    logic [7:0]  b;
    s = 16'hFFFF;
    for (int n = 0; n < 2048; n++) begin
      for (int i = 0; i < 8; i++) begin
        b[i] = s[15];
        s    = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
      end
      ks[n] = b;
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_idx[m] = 0; m_locked[m] = 0; m_gap[m] = 0; e_dout[m] = 8'h00; e_lost[m] = 1'b0;
    end
    e_valid = 1'b0; e_k = 1'b0; e_dis = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic k, input logic dis);
    bit com, skp;
    com = k && (d == 8'hBC);
    skp = k && (d == 8'h1C);
    e_valid = v;
    for (int m = 0; m < 2; m++) begin
      e_lost[m] = 1'b0;
      if (v) begin
        e_dout[m] = (!k && m_locked[m] && !dis) ? (d ^ ks[m_idx[m]]) : d;
        if (com) m_idx[m] = 0;
        else if (!skp) m_idx[m] = m_idx[m] + 1;
        if (com) begin
          m_locked[m] = 1; m_gap[m] = 0;
        end else if (m_locked[m]) begin
          m_gap[m] = m_gap[m] + 1;
          if (m_gap[m] >= tmo[m]) begin
            m_locked[m] = 0; e_lost[m] = 1'b1;
          end
        end
      end
    end
    if (v) begin
      e_k = k; e_dis = dis;
    end
  endtask

  task automatic check_all();
    chk("valid_a", 16'(valid_a), 16'(e_valid));
    chk("dout_a", 16'(dout_a), 16'(e_dout[0]));
    chk("k_a", 16'(k_a), 16'(e_k));
    chk("dis_a", 16'(dis_a), 16'(e_dis));
    chk("locked_a", 16'(locked_a), 16'(m_locked[0]));
    chk("lost_a", 16'(lost_a), 16'(e_lost[0]));
    chk("valid_t", 16'(valid_t), 16'(e_valid));
    chk("dout_t", 16'(dout_t), 16'(e_dout[1]));
    chk("k_t", 16'(k_t), 16'(e_k));
    chk("dis_t", 16'(dis_t), 16'(e_dis));
    chk("locked_t", 16'(locked_t), 16'(m_locked[1]));
    chk("lost_t", 16'(lost_t), 16'(e_lost[1]));
  endtask

  // Present one input cycle, then sample 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic [7:0] d, input logic k, input logic dis);
    valid_in = v; din = d; k_in = k; dis_scrambler_in = dis;
    model_step(v, d, k, dis);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 16'(valid_a), 16'h0);
    chk({tag, "_dout"}, 16'(dout_a), 16'h0);
    chk({tag, "_k"}, 16'(k_a), 16'h0);
    chk({tag, "_dis"}, 16'(dis_a), 16'h0);
    chk({tag, "_locked"}, 16'(locked_a), 16'h0);
    chk({tag, "_lost"}, 16'(lost_a), 16'h0);
    chk({tag, "_locked_t"}, 16'(locked_t), 16'h0);
    chk({tag, "_dout_t"}, 16'(dout_t), 16'h0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0; din = 8'h00; k_in = 1'b0; dis_scrambler_in = 1'b0;
    rst = 1'b1;
    #2;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_ff[8];
    logic [7:0] d, orig;
    logic       k;
    int         pos, tx_idx;

    exp_ff = '{8'h00, 8'hE8, 8'h3F, 8'hEB, 8'h4D, 8'h18, 8'hFD, 8'h7D};
    build_keystream();
    model_reset();
    rst = 1'b1; valid_in = 1'b0; din = 8'h00; k_in = 1'b0; dis_scrambler_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst = 1'b0;

    // Data before any COM passes raw.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("precom_dout", 16'(dout_a), 16'h0055);
    chk("precom_locked", 16'(locked_a), 16'h0);

    // COM then 0xFF x8 gives the inverted seed keystream.
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    chk("com_locked", 16'(locked_a), 16'h1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("ff_seq", 16'(dout_a), 16'(exp_ff[i]));
    end

    // Timeout-16 instance drops lock on the 16th non-COM symbol.
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      if (i == 15) chk("tmo_pre_locked", 16'(locked_t), 16'h1);
    end
    chk("tmo_locked_fall", 16'(locked_t), 16'h0);
    chk("tmo_lost_pulse", 16'(lost_t), 16'h1);
    step(1'b1, 8'h3A, 1'b0, 1'b0);
    chk("tmo_lost_single", 16'(lost_t), 16'h0);
    chk("tmo_raw_after", 16'(dout_t), 16'h003A);

    // COM as the 16th symbol keeps lock with no pulse.
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    chk("com_wins_locked", 16'(locked_t), 16'h1);
    chk("com_wins_nolost", 16'(lost_t), 16'h0);

    // Scrambling disabled for four symbols, then resumed at keystream byte 4.
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      step(1'b1, d, 1'b0, 1'b1);
      chk("dis_raw", 16'(dout_a), 16'(d));
    end
    d = 8'($urandom);
    step(1'b1, d, 1'b0, 1'b0);
    chk("dis_resume", 16'(dout_a), 16'(d ^ 8'hB2));

    // Reset mid-packet clears everything; data is raw until the next COM.
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("postrst_raw", 16'(dout_a), 16'h003C);
    chk("postrst_unlocked", 16'(locked_a), 16'h0);
    step(1'b1, 8'hBC, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("postrst_descr", 16'(dout_a), 16'h0000);

    // End-to-end: transmit-side scrambling of a random stream with gaps.
    pos = 0;
    tx_idx = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) begin
        step(1'b0, 8'($urandom), 1'($urandom), 1'b0);
        chk("gap_valid", 16'(valid_a), 16'h0);
      end else begin
        if (pos % 20 == 0) begin
          orig = 8'hBC; d = 8'hBC; k = 1'b1; tx_idx = 0;
        end else if (pos % 20 == 9) begin
          orig = 8'h1C; d = 8'h1C; k = 1'b1;
        end else if (pos % 20 == 15) begin
          orig = 8'hF7; d = 8'hF7; k = 1'b1; tx_idx++;
        end else begin
          orig = 8'($urandom); d = orig ^ ks[tx_idx]; k = 1'b0; tx_idx++;
        end
        step(1'b1, d, k, 1'b0);
        chk("e2e_dout", 16'(dout_a), 16'(orig));
        chk("e2e_locked", 16'(locked_a), 16'h1);
        pos++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
